// File: rtl/count_uart_reporter_pkg.sv
// Shared definitions for the count UART reporter.
//  - ASCII constants used to build the report text
//  - serializer state type
//  - report length and the byte-selection helper
package cur_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;

  // Bytes per report: four hex digits, CR, LF.
  localparam int MSG_LEN = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

  // Upper-case ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A_OFS + {4'h0, n});
  endfunction

  // Byte idx of the report for value v: MSN first, then CR, LF.
  function automatic logic [7:0] msg_byte(input logic [15:0] v, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hex_ascii(v[15:12]);
      3'd1:    b = hex_ascii(v[11:8]);
      3'd2:    b = hex_ascii(v[7:4]);
      3'd3:    b = hex_ascii(v[3:0]);
      3'd4:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter, one frame per handshake, LSB first, idle high.
// Ports:
//  clk, rst_n   clock, synchronous active-low reset
//  byte_i       byte to send, taken on valid_i & ready_o
//  valid_i      a byte is offered
//  ready_o      1 in IDLE and in the final cycle of the stop bit
//  txd_o        registered serial line
// Handshake: a byte is transferred at a rising edge where valid_i and
// ready_o are both 1; valid_i may drop at any time no transfer occurs.
// Because ready_o is also high in the last stop-bit cycle, a byte offered
// then starts its start bit at the very next bit boundary (no idle gap).
module uart_tx_byte
  import cur_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  ser_state_t       state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             txd_q;
  logic             bit_end;

  assign bit_end = (tmr == TMR_LAST);
  assign ready_o = (state == IDLE) || ((state == STOP) && bit_end);
  assign txd_o   = txd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd_q   <= 1'b1;
    end else begin
      // Bit timer runs in every non-idle state and wraps at each bit boundary.
      if (state != IDLE) tmr <= bit_end ? '0 : tmr + TMR_W'(1);
      case (state)
        IDLE: begin
          if (valid_i) begin
            state <= START;
            tmr   <= '0;
            shreg <= byte_i;
            txd_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            txd_q   <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (valid_i) begin
              state <= START;
              shreg <= byte_i;
              txd_q <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/count_uart_reporter.sv
// Snapshots a 16-bit counter on request and sends it over a UART line as
// four upper-case hex digits (MSN first) followed by CR LF.
// Ports:
//  clk, rst_n   clock, synchronous active-low reset
//  count_i      live counter value, sampled when a request is accepted
//  trig_i       report request, level-sampled; ignored while busy_o=1
//  txd_o        8N1 serial output, idle high, registered
//  busy_o       high while a report is in flight, registered
//  done_o       one-cycle pulse at the end of a report, registered
module count_uart_reporter
  import cur_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] count_i,
  input  logic        trig_i,
  output logic        txd_o,
  output logic        busy_o,
  output logic        done_o
);

  logic [15:0] snap;
  logic [2:0]  byte_idx;   // byte currently on the line
  logic        busy_q;
  logic        done_q;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        accept;
  logic        last_byte;

  // When idle the serializer is always ready, so byte 0 is fed straight
  // from count_i and its start bit goes out on the accepting edge.
  assign accept    = trig_i && !busy_q && tx_ready;
  assign last_byte = (byte_idx == 3'(MSG_LEN - 1));
  assign tx_valid  = accept || (busy_q && !last_byte);
  assign tx_byte   = busy_q ? msg_byte(snap, byte_idx + 3'd1) : msg_byte(count_i, 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap     <= '0;
      byte_idx <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        snap     <= count_i;
        byte_idx <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q && tx_ready) begin
        // tx_ready while busy only occurs in the last stop-bit cycle.
        if (last_byte) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .byte_i (tx_byte),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .txd_o  (txd_o)
  );

endmodule
